// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the time-multiplexed FIR tap scheduler:
//   - fir_state_e   : sequencer states (IDLE waits for a sample, MAC walks taps)
//   - acc_w()       : accumulator/output width for a given sample width and
//                     tap count (sized so the full tap sum cannot overflow)
//   - FIR_CNT_W_DEF : default width of the optional drop counter
// -----------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic [0:0] {
        FIR_IDLE = 1'b0,
        FIR_MAC  = 1'b1
    } fir_state_e;

    localparam int FIR_CNT_W_DEF = 16;

    // Product of two n-bit values is 2n bits; summing taps of them needs
    // clog2(taps) extra bits of headroom.
    function automatic int acc_w(input int n, input int taps);
        return (2 * n) + $clog2(taps);
    endfunction

endpackage : fir_pkg

// File: rtl/fir_coef_bank.sv
// -----------------------------------------------------------------------------
// fir_coef_bank
// TAPS x N coefficient register file with one write port and one
// combinational read port. Clears to zero on synchronous active-low reset.
// A write and a read of the same index on one edge returns the old value,
// because the read is taken from the register contents before the edge.
//
// Ports:
//   i_clk     in   clock, rising edge
//   i_rst_n   in   synchronous active-low reset
//   i_we      in   write strobe
//   i_addr    in   write index
//   i_data    in   write value
//   i_raddr   in   read index (tap sequencer)
//   o_rdata   out  coefficient at i_raddr
// -----------------------------------------------------------------------------
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int N    = 16,
    parameter int TAPS = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_we,
    input  logic [$clog2(TAPS)-1:0] i_addr,
    input  logic [N-1:0]            i_data,
    input  logic [$clog2(TAPS)-1:0] i_raddr,
    output logic [N-1:0]            o_rdata
);

    localparam int AW = $clog2(TAPS);

    logic [N-1:0] r_coef [TAPS];

    // Coefficient storage: reset to zero, otherwise load the addressed entry.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                r_coef[k] <= {N{1'b0}};
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (i_we && (i_addr == AW'(k))) begin
                    r_coef[k] <= i_data;
                end
            end
        end
    end

    assign o_rdata = r_coef[i_raddr];

endmodule : fir_coef_bank

// File: rtl/fir_tap_scheduler.sv
// -----------------------------------------------------------------------------
// fir_tap_scheduler
// Time-multiplexed FIR: one output per accepted sample, produced by walking a
// single multiply-accumulate over the TAPS delay-line entries. x[0] is the
// newest sample and is weighted by c[0].
//
// Optional build macro: FIR_TAP_SCHED_DROP_CNT_EN adds DROP_CNT, a saturating
// count of samples offered (EN=1, R_IN=1) while a pass was in progress.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST_N      in   synchronous active-low reset
//   EN         in   global enable; low freezes sequencing
//   R_IN       in   input sample valid (only honoured while idle)
//   D_IN       in   input sample, N bits unsigned
//   BUSY       out  high while a MAC pass is running
//   COEF_WE    in   coefficient write strobe (independent of EN/state)
//   COEF_ADDR  in   coefficient index
//   COEF_DATA  in   coefficient value, N bits unsigned
//   R_OUT      out  one-cycle result valid pulse
//   D_OUT      out  filter result, held until the next result
//   DROP_CNT   out  (macro only) dropped-sample counter
//
// Latency: accept at edge t0 -> R_OUT/D_OUT valid after edge t0+TAPS with EN
// held high; a new sample can be accepted in the R_OUT cycle.
// -----------------------------------------------------------------------------
module fir_tap_scheduler
    import fir_pkg::*;
#(
    parameter int N    = 16,
    parameter int TAPS = 8
`ifdef FIR_TAP_SCHED_DROP_CNT_EN
    ,
    parameter int CNT_W = FIR_CNT_W_DEF
`endif
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        EN,
    input  logic                        R_IN,
    input  logic [N-1:0]                D_IN,
    output logic                        BUSY,
    input  logic                        COEF_WE,
    input  logic [$clog2(TAPS)-1:0]     COEF_ADDR,
    input  logic [N-1:0]                COEF_DATA,
    output logic                        R_OUT,
    output logic [acc_w(N, TAPS)-1:0]   D_OUT
`ifdef FIR_TAP_SCHED_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]            DROP_CNT
`endif
);

    localparam int ACC_W = acc_w(N, TAPS);
    localparam int AW    = $clog2(TAPS);

    localparam logic [0:0] S_IDLE = FIR_IDLE;
    localparam logic [0:0] S_MAC  = FIR_MAC;

    localparam logic [AW-1:0] IDX_LAST = AW'(TAPS - 1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);

    logic [0:0]       r_state;
    logic [AW-1:0]    r_idx;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_dout;
    logic             r_rout;
    logic [N-1:0]     r_x [TAPS];

    logic [N-1:0]     w_coef;
    logic [2*N-1:0]   w_prod;
    logic [ACC_W-1:0] w_sum;
    logic             w_busy;

    fir_coef_bank #(
        .N    (N),
        .TAPS (TAPS)
    ) u_coef_bank (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_we    (COEF_WE),
        .i_addr  (COEF_ADDR),
        .i_data  (COEF_DATA),
        .i_raddr (r_idx),
        .o_rdata (w_coef)
    );

    // Operands widened before the multiply so the full 2N-bit product is kept.
    assign w_prod = {{N{1'b0}}, r_x[r_idx]} * {{N{1'b0}}, w_coef};
    assign w_sum  = r_acc + {{AW{1'b0}}, w_prod};
    assign w_busy = (r_state == S_MAC);

    // Sequencer, delay line and accumulator. R_OUT defaults low every edge so
    // it stays a single pulse even when EN drops right after a result.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_idx   <= {AW{1'b0}};
            r_acc   <= {ACC_W{1'b0}};
            r_dout  <= {ACC_W{1'b0}};
            r_rout  <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= {N{1'b0}};
            end
        end else begin
            r_rout <= 1'b0;
            if (EN) begin
                case (r_state)
                    S_IDLE: begin
                        if (R_IN) begin
                            for (int k = TAPS - 1; k > 0; k--) begin
                                r_x[k] <= r_x[k-1];
                            end
                            r_x[0]  <= D_IN;
                            r_acc   <= {ACC_W{1'b0}};
                            r_idx   <= {AW{1'b0}};
                            r_state <= S_MAC;
                        end
                    end
                    S_MAC: begin
                        r_acc <= w_sum;
                        if (r_idx == IDX_LAST) begin
                            r_dout  <= w_sum;
                            r_rout  <= 1'b1;
                            r_idx   <= {AW{1'b0}};
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + IDX_ONE;
                        end
                    end
                    default: begin
                        r_idx   <= {AW{1'b0}};
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign BUSY  = w_busy;
    assign R_OUT = r_rout;
    assign D_OUT = r_dout;

`ifdef FIR_TAP_SCHED_DROP_CNT_EN
    logic [CNT_W-1:0] r_drop;

    // Count samples offered while a pass is running; holds at all-ones.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_drop <= {CNT_W{1'b0}};
        end else if (EN && R_IN && w_busy && (r_drop != {CNT_W{1'b1}})) begin
            r_drop <= r_drop + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign DROP_CNT = r_drop;
`endif

endmodule : fir_tap_scheduler
